// File: rtl/combinational_karatsuba_pkg.sv
// combinational_karatsuba_pkg: default widths and split helper shared by the Karatsuba multiplier files
package combinational_karatsuba_pkg;
  localparam int DEF_N = 16;
  localparam int DEF_BASE_W = 4;
  function automatic int half_w(input int w);
    return w / 2;
  endfunction
endpackage

// File: rtl/combinational_karatsuba_if.sv
// combinational_karatsuba_if: operand/product bundle between a multiplier and its user
interface combinational_karatsuba_if
  import combinational_karatsuba_pkg::*;
#(
  parameter int N = DEF_N
);
  logic [N-1:0]   X;
  logic [N-1:0]   Y;
  logic [2*N-1:0] Z;
  logic [2*N-1:0] Z_q;
  modport master(output X, output Y, input Z, input Z_q);
  modport slave(input X, input Y, output Z, output Z_q);
endinterface

// File: rtl/combinational_karatsuba_core.sv
// karatsuba_core: recursive unsigned W x W Karatsuba multiplier, direct multiply at or below BASE_W
module karatsuba_core
  import combinational_karatsuba_pkg::*;
#(
  parameter int W = DEF_N,
  parameter int BASE_W = DEF_BASE_W
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  if (W <= BASE_W) begin : g_base
    assign p = (2*W)'(a) * (2*W)'(b);
  end else begin : g_rec
    localparam int H = half_w(W);
    localparam int PW = 2*H + 2;
    logic [H:0]     w_sa, w_sb;
    logic [2*H-1:0] w_p2, w_p0, w_mm;
    logic [PW-1:0]  w_pm, w_p1;
    assign w_sa = {1'b0, a[W-1:H]} + {1'b0, a[H-1:0]};
    assign w_sb = {1'b0, b[W-1:H]} + {1'b0, b[H-1:0]};
    karatsuba_core #(.W(H), .BASE_W(BASE_W)) u_p2 (.a(a[W-1:H]), .b(b[W-1:H]), .p(w_p2));
    karatsuba_core #(.W(H), .BASE_W(BASE_W)) u_p0 (.a(a[H-1:0]), .b(b[H-1:0]), .p(w_p0));
    karatsuba_core #(.W(H), .BASE_W(BASE_W)) u_pm (.a(w_sa[H-1:0]), .b(w_sb[H-1:0]), .p(w_mm));
    // (h+1)-bit middle product: low-half product plus cross terms for the half-sum carries
    assign w_pm = PW'(w_mm)
                + ({PW{w_sa[H]}} & (PW'(w_sb[H-1:0]) << H))
                + ({PW{w_sb[H]}} & (PW'(w_sa[H-1:0]) << H))
                + (PW'(w_sa[H] & w_sb[H]) << (2*H));
    assign w_p1 = w_pm - PW'(w_p2) - PW'(w_p0);
    assign p = {w_p2, w_p0} + ((2*W)'(w_p1) << H);
  end
endmodule

// File: rtl/combinational_karatsuba.sv
// combinational_karatsuba: combinational Karatsuba product Z plus a registered copy Z_q
module combinational_karatsuba
  import combinational_karatsuba_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int BASE_W = DEF_BASE_W
) (
  input logic clk,
  input logic rst_n,
  combinational_karatsuba_if.slave bus
);
  logic [2*N-1:0] w_z;
  logic [2*N-1:0] r_zq;
  karatsuba_core #(.W(N), .BASE_W(BASE_W)) u_core (.a(bus.X), .b(bus.Y), .p(w_z));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_zq <= '0;
    else r_zq <= w_z;
  end
  assign bus.Z = w_z;
  assign bus.Z_q = r_zq;
endmodule

// File: tb/tb_combinational_karatsuba.sv
// tb_combinational_karatsuba: table, sweep, random and reset/latency checks against plain X*Y
module tb_combinational_karatsuba;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  combinational_karatsuba_if #(.N(16)) b16 ();
  combinational_karatsuba_if #(.N(8))  b8 ();
  combinational_karatsuba_if #(.N(32)) b32 ();
  combinational_karatsuba #(.N(16), .BASE_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b16));
  combinational_karatsuba #(.N(8),  .BASE_W(2)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  combinational_karatsuba #(.N(32), .BASE_W(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] z;
  } vec_t;
  vec_t tbl[$];
  logic [15:0] corners[6] = '{16'h0000, 16'h0001, 16'h00FF, 16'hFF00, 16'h8000, 16'hFFFF};
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return 64'(x) * 64'(y);
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  initial begin
    b16.X = 16'd3; b16.Y = 16'd5; b8.X = '0; b8.Y = '0; b32.X = '0; b32.Y = '0;
    #1;
    chk("reset_z", 64'(b16.Z), 64'd15);
    chk("reset_zq", 64'(b16.Z_q), 64'd0);
    @(posedge clk); #1;
    chk("reset_zq_after_edge", 64'(b16.Z_q), 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("release_before_edge", 64'(b16.Z_q), 64'd0);
    @(posedge clk); #1;
    chk("release_zq", 64'(b16.Z_q), 64'd15);
    @(negedge clk); b16.X = 16'd7; #1;
    chk("latency_z_same_cycle", 64'(b16.Z), 64'd35);
    chk("latency_zq_held", 64'(b16.Z_q), 64'd15);
    @(posedge clk); #1;
    chk("latency_zq_next_edge", 64'(b16.Z_q), 64'd35);
    #2 rst_n = 1'b0; #1;
    chk("midstream_reset_zq", 64'(b16.Z_q), 64'd0);
    b16.X = 16'd9; #1;
    chk("midstream_reset_z", 64'(b16.Z), 64'd45);
    @(posedge clk); #1;
    chk("reset_holds_zq", 64'(b16.Z_q), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rerelease_zq", 64'(b16.Z_q), 64'd45);
    tbl.push_back('{16'hFFFF, 16'hFFFF, 32'hFFFE0001});
    tbl.push_back('{16'h0FFF, 16'hF0FF, 32'h0F0EFF01});
    tbl.push_back('{16'h00FF, 16'hFF00, 32'h00FE0100});
    tbl.push_back('{16'h8000, 16'h8000, 32'h40000000});
    tbl.push_back('{16'hFFFF, 16'h8000, 32'h7FFF8000});
    tbl.push_back('{16'h00FF, 16'h00FF, 32'h0000FE01});
    tbl.push_back('{16'h03E7, 16'hFFFF, 32'd65469465});
    tbl.push_back('{16'h0000, 16'hFFFF, 32'h00000000});
    tbl.push_back('{16'hFFFF, 16'h0000, 32'h00000000});
    for (int i = 0; i < tbl.size(); i++) begin
      b16.X = tbl[i].x; b16.Y = tbl[i].y; #1;
      chk($sformatf("table[%0d]", i), 64'(b16.Z), 64'(tbl[i].z));
    end
    b16.X = 16'hFFFF; b16.Y = 16'hFFFF;
    @(posedge clk); #1;
    chk("zq_max", 64'(b16.Z_q), 64'hFFFE0001);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) begin
        b16.X = corners[i]; b16.Y = corners[j]; #1;
        chk($sformatf("corner %h*%h", corners[i], corners[j]), 64'(b16.Z), ref_mul(32'(corners[i]), 32'(corners[j])));
      end
    b16.Y = 16'hFFFF;
    for (int x = 0; x < 1000; x++) begin
      b16.X = 16'(x); #1;
      chk($sformatf("sweep x=%0d", x), 64'(b16.Z), 64'(x) * 64'd65535);
    end
    b8.X = 8'hFF; b8.Y = 8'hFF; b32.X = 32'hFFFF_FFFF; b32.Y = 32'hFFFF_FFFF; #1;
    chk("n8_max", 64'(b8.Z), 64'hFE01);
    chk("n32_max", 64'(b32.Z), 64'hFFFF_FFFE_0000_0001);
    for (int i = 0; i < 100000; i++) begin
      b16.X = 16'($urandom); b16.Y = 16'($urandom);
      b8.X = 8'($urandom); b8.Y = 8'($urandom);
      b32.X = $urandom; b32.Y = $urandom;
      #1;
      chk("rand16", 64'(b16.Z), ref_mul(32'(b16.X), 32'(b16.Y)));
      if (i % 10 == 0) begin
        chk("rand8", 64'(b8.Z), ref_mul(32'(b8.X), 32'(b8.Y)));
        chk("rand32", 64'(b32.Z), ref_mul(b32.X, b32.Y));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
